// File: rtl/game_pkg.sv
// Shared types and constants for the game score bus master.
package game_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned DEF_MAX_SCORE = 999;

    localparam logic [ADDR_W-1:0] ADDR_STATE = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_P1    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_P2    = ADDR_W'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ST_WR = 2'd1,
        RD    = 2'd2,
        WR    = 2'd3
    } bus_state_e;

endpackage

// File: rtl/game_bus_master_pend_counter.sv
// Per-player pending-event counter: saturates at all-ones, flags dropped events,
// and holds its value when an increment and a decrement coincide.
module pend_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_nxt_c,
    output logic         ovf_c
);

    logic [W-1:0] count_q;

    always_comb begin
        count_nxt_c = count_q;
        ovf_c       = 1'b0;
        if (inc_i && !dec_i) begin
            if (&count_q) begin
                ovf_c = 1'b1;
            end else begin
                count_nxt_c = count_q + W'(1);
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_nxt_c = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt_c;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/game_bus_master.sv
// Bus master that writes game state and read-modify-writes player scores.
// Optional SCORE_SAT_EN clamps score increments at MAX_SCORE.
module game_bus_master
    import game_pkg::*;
#(
    parameter int unsigned MAX_SCORE = DEF_MAX_SCORE,
    parameter int unsigned PEND_W    = 4
) (
    input  logic              Clk,
    input  logic              Reset_h,
    input  logic              P1_point,
    input  logic              P2_point,
    input  logic              State_req,
    input  logic [DATA_W-1:0] State_val,
    output logic [ADDR_W-1:0] Address,
    output logic              Chip_select_h,
    output logic              Read_h,
    output logic              Write_h,
    output logic [DATA_W-1:0] Write_data,
    input  logic [DATA_W-1:0] Read_data,
    input  logic              Wait_h,
    output logic              Busy,
    output logic              Overflow
);

    bus_state_e        state_q, state_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              st_pend_q, st_pend_d;
    logic [DATA_W-1:0] st_val_q, st_val_d;
    logic              st_take;
    logic              dec_p1, dec_p2;

    logic [PEND_W-1:0] p1_cnt, p1_cnt_nxt;
    logic [PEND_W-1:0] p2_cnt, p2_cnt_nxt;
    logic              p1_ovf, p2_ovf;

    function automatic logic [DATA_W-1:0] score_inc(input logic [DATA_W-1:0] rd);
`ifdef SCORE_SAT_EN
        if (rd >= DATA_W'(MAX_SCORE)) begin
            return DATA_W'(MAX_SCORE);
        end
        return rd + DATA_W'(1);
`else
        return rd + DATA_W'(1);
`endif
    endfunction

    pend_counter #(.W(PEND_W)) u_p1_pend (
        .clk_i       (Clk),
        .rst_i       (Reset_h),
        .inc_i       (P1_point),
        .dec_i       (dec_p1),
        .count_o     (p1_cnt),
        .count_nxt_c (p1_cnt_nxt),
        .ovf_c       (p1_ovf)
    );

    pend_counter #(.W(PEND_W)) u_p2_pend (
        .clk_i       (Clk),
        .rst_i       (Reset_h),
        .inc_i       (P2_point),
        .dec_i       (dec_p2),
        .count_o     (p2_cnt),
        .count_nxt_c (p2_cnt_nxt),
        .ovf_c       (p2_ovf)
    );

    // Next-state and next-output logic; strobes are computed one cycle ahead so they leave flops.
    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        st_take = 1'b0;
        dec_p1  = 1'b0;
        dec_p2  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (st_pend_q) begin
                    state_d = ST_WR;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_STATE;
                    data_d  = st_val_q;
                    st_take = 1'b1;
                end else if (p1_cnt != '0) begin
                    state_d = RD;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_P1;
                end else if (p2_cnt != '0) begin
                    state_d = RD;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_P2;
                end
            end
            ST_WR, WR: begin
                if (Wait_h) begin
                    cs_d = 1'b1;
                    wr_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (Wait_h) begin
                    cs_d = 1'b1;
                    rd_d = 1'b1;
                end else begin
                    state_d = WR;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    data_d  = score_inc(Read_data);
                    dec_p1  = (addr_q == ADDR_P1);
                    dec_p2  = (addr_q == ADDR_P2);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new request in the dispatch cycle survives as the next pending write.
    always_comb begin
        st_pend_d = st_pend_q;
        st_val_d  = st_val_q;
        if (State_req) begin
            st_pend_d = 1'b1;
            st_val_d  = State_val;
        end else if (st_take) begin
            st_pend_d = 1'b0;
        end
        busy_d = (state_d != IDLE) || st_pend_d || (p1_cnt_nxt != '0) || (p2_cnt_nxt != '0);
        ovf_d  = ovf_q || p1_ovf || p2_ovf;
    end

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= ADDR_STATE;
            data_q    <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            st_pend_q <= 1'b0;
            st_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            st_pend_q <= st_pend_d;
            st_val_q  <= st_val_d;
        end
    end

    assign Address       = addr_q;
    assign Chip_select_h = cs_q;
    assign Read_h        = rd_q;
    assign Write_h       = wr_q;
    assign Write_data    = data_q;
    assign Busy          = busy_q;
    assign Overflow      = ovf_q;

endmodule

// File: tb/tb_game_bus_master.sv
// Directed bench for game_bus_master with a three-register bus slave model.
module tb_game_bus_master;

    logic        Clk = 1'b0;
    logic        Reset_h;
    logic        P1_point, P2_point, State_req;
    logic [31:0] State_val;
    logic [2:0]  Address;
    logic        Chip_select_h, Read_h, Write_h;
    logic [31:0] Write_data, Read_data;
    logic        Wait_h;
    logic        Busy, Overflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mem [0:7];
    int unsigned wr_cnt = 0;
    logic [2:0]  log_addr [$];
    logic [31:0] log_data [$];

    always #5 Clk = ~Clk;

    game_bus_master dut (
        .Clk           (Clk),
        .Reset_h       (Reset_h),
        .P1_point      (P1_point),
        .P2_point      (P2_point),
        .State_req     (State_req),
        .State_val     (State_val),
        .Address       (Address),
        .Chip_select_h (Chip_select_h),
        .Read_h        (Read_h),
        .Write_h       (Write_h),
        .Write_data    (Write_data),
        .Read_data     (Read_data),
        .Wait_h        (Wait_h),
        .Busy          (Busy),
        .Overflow      (Overflow)
    );

    assign Read_data = mem[Address];

    // Slave accepts a write on any clock where the master writes and is not stalled.
    always @(posedge Clk) begin
        if (!Reset_h && Chip_select_h && Write_h && !Wait_h) begin
            mem[Address] = Write_data;
            wr_cnt = wr_cnt + 1;
            log_addr.push_back(Address);
            log_data.push_back(Write_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (Busy && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(Busy), 32'd0);
    endtask

    logic [31:0] sat_in  [3] = '{32'hFFFF_FFFF, 32'd998, 32'd41};
`ifdef SCORE_SAT_EN
    logic [31:0] sat_exp [3] = '{32'd999, 32'd999, 32'd42};
`else
    logic [31:0] sat_exp [3] = '{32'd0, 32'd999, 32'd42};
`endif
    logic [2:0]  ord_addr [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] ord_data [3] = '{32'd3, 32'd7, 32'd11};

    initial begin
        int unsigned wc0;
        logic [31:0] m1;

        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        Reset_h   = 1'b1;
        P1_point  = 1'b0;
        P2_point  = 1'b0;
        State_req = 1'b0;
        State_val = 32'd0;
        Wait_h    = 1'b0;
        tick(2);
        check("rst_busy",  32'(Busy), 32'd0);
        check("rst_cs",    32'(Chip_select_h), 32'd0);
        check("rst_rd",    32'(Read_h), 32'd0);
        check("rst_wr",    32'(Write_h), 32'd0);
        check("rst_addr",  32'(Address), 32'd0);
        check("rst_wdata", Write_data, 32'd0);
        check("rst_ovf",   32'(Overflow), 32'd0);
        Reset_h = 1'b0;
        tick();

        // Single P1 point, no stall: IDLE, RD, WR, then idle.
        mem[1] = 32'd5;
        P1_point = 1'b1;
        tick();
        P1_point = 1'b0;
        check("a_busy_c1", 32'(Busy), 32'd1);
        check("a_rd_c1",   32'(Read_h), 32'd0);
        tick();
        check("a_rd_c2",   32'(Read_h), 32'd1);
        check("a_cs_c2",   32'(Chip_select_h), 32'd1);
        check("a_addr_c2", 32'(Address), 32'd1);
        check("a_wr_c2",   32'(Write_h), 32'd0);
        tick();
        check("a_wr_c3",   32'(Write_h), 32'd1);
        check("a_rd_c3",   32'(Read_h), 32'd0);
        check("a_wd_c3",   Write_data, 32'd6);
        tick();
        check("a_busy_c4", 32'(Busy), 32'd0);
        check("a_wr_c4",   32'(Write_h), 32'd0);
        check("a_mem1",    mem[1], 32'd6);

        // Simultaneous requests: state write, then P1, then P2.
        mem[2] = 32'd10;
        log_addr.delete();
        log_data.delete();
        P1_point  = 1'b1;
        P2_point  = 1'b1;
        State_req = 1'b1;
        State_val = 32'd3;
        tick();
        P1_point  = 1'b0;
        P2_point  = 1'b0;
        State_req = 1'b0;
        wait_idle("b_idle", 40);
        check("b_nwr", 32'(log_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_addr%0d", i), (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hFFFF_FFFF, 32'(ord_addr[i]));
            check($sformatf("b_data%0d", i), (i < log_data.size()) ? log_data[i] : 32'hFFFF_FFFF, ord_data[i]);
        end

        // Stall four cycles in WR: strobe and data must hold, one write accepted.
        P2_point = 1'b1;
        tick();
        P2_point = 1'b0;
        tick(2);
        check("c_wr_start", 32'(Write_h), 32'd1);
        Wait_h = 1'b1;
        wc0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("c_wr_hold%0d", i), 32'(Write_h), 32'd1);
            check($sformatf("c_wd_hold%0d", i), Write_data, 32'd12);
            check($sformatf("c_rd_low%0d", i), 32'(Read_h), 32'd0);
            check($sformatf("c_nowr%0d", i), wr_cnt, wc0);
        end
        Wait_h = 1'b0;
        tick();
        check("c_one_wr", wr_cnt, wc0 + 1);
        check("c_mem2",   mem[2], 32'd12);
        check("c_wr_end", 32'(Write_h), 32'd0);

        // 20 P2 points while stalled: 15 recorded, 5 dropped.
        check("d_ovf_pre", 32'(Overflow), 32'd0);
        Wait_h = 1'b1;
        wc0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            P2_point = 1'b1;
            tick();
            P2_point = 1'b0;
            tick();
        end
        check("d_ovf",  32'(Overflow), 32'd1);
        check("d_busy", 32'(Busy), 32'd1);
        Wait_h = 1'b0;
        wait_idle("d_idle", 200);
        check("d_nwr",  wr_cnt - wc0, 32'd15);
        check("d_mem2", mem[2], 32'd27);
        check("d_ovf_sticky", 32'(Overflow), 32'd1);

        // Increment boundary: wrap or clamp depending on build.
        for (int i = 0; i < 3; i++) begin
            mem[1] = sat_in[i];
            P1_point = 1'b1;
            tick();
            P1_point = 1'b0;
            wait_idle($sformatf("e_idle%0d", i), 20);
            check($sformatf("e_score%0d", i), mem[1], sat_exp[i]);
        end

        // Reset during RD abandons the transfer and clears pending work.
        wc0 = wr_cnt;
        m1 = mem[1];
        P1_point = 1'b1;
        P2_point = 1'b1;
        tick();
        P1_point = 1'b0;
        P2_point = 1'b0;
        tick();
        check("f_rd", 32'(Read_h), 32'd1);
        Reset_h = 1'b1;
        #1;
        check("f_rd_drop", 32'(Read_h), 32'd0);
        check("f_cs_drop", 32'(Chip_select_h), 32'd0);
        check("f_wr_low",  32'(Write_h), 32'd0);
        check("f_busy",    32'(Busy), 32'd0);
        tick();
        Reset_h = 1'b0;
        tick(6);
        check("f_nowr",    wr_cnt, wc0);
        check("f_mem1",    mem[1], m1);
        check("f_idle",    32'(Busy), 32'd0);
        check("f_ovf_clr", 32'(Overflow), 32'd0);
        check("f_p1cnt",   32'(dut.u_p1_pend.count_o), 32'd0);
        check("f_p2cnt",   32'(dut.u_p2_pend.count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_bus_master.md
GAME_BUS_MASTER -- requirements
Module: game_bus_master

Interface
REQ-001 Parameter MAX_SCORE, default 999, SHALL be the score ceiling used when SCORE_SAT_EN is defined.
REQ-002 Parameter PEND_W, default 4, SHALL be the width of each per-player pending-event counter.
REQ-003 Clk  input  1  SHALL be the single clock; all state SHALL update on posedge Clk.
REQ-004 Reset_h  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 P1_point  input  1  SHALL be a one-cycle pulse requesting +1 to the Player 1 score.
REQ-006 P2_point  input  1  SHALL be a one-cycle pulse requesting +1 to the Player 2 score.
REQ-007 State_req  input  1  SHALL be a one-cycle pulse requesting a write of State_val to the game-state register.
REQ-008 State_val  input  32  SHALL be the game-state value, sampled in the cycle State_req is high.
REQ-009 Address  output  3  SHALL be the bus register address: 0 = state, 1 = P1 score, 2 = P2 score.
REQ-010 Chip_select_h, Read_h, Write_h  output  1 each  SHALL be the bus select, read strobe and write strobe.
REQ-011 Write_data  output  32  SHALL be the bus write data.
REQ-012 Read_data  input  32  SHALL be the bus read data, valid in any cycle where Read_h, Chip_select_h and !Wait_h are all high.
REQ-013 Wait_h  input  1  SHALL be the slave stall; a transfer SHALL complete only in a cycle where Wait_h is low.
REQ-014 Busy  output  1  SHALL be high whenever the FSM is not in IDLE or any request is pending.
REQ-015 Overflow  output  1  SHALL be a sticky flag, set when a score event is dropped because its pending counter is full.

Function
REQ-016 FSM states SHALL be IDLE, ST_WR, RD, WR.
REQ-017 In IDLE, the FSM SHALL select the highest-priority pending request: state write, then P1, then P2.
REQ-018 ST_WR SHALL assert Chip_select_h, Write_h, Address=0 and Write_data=latched State_val until a cycle with Wait_h low, then return to IDLE.
REQ-019 RD SHALL assert Chip_select_h, Read_h and Address=player; on a cycle with Wait_h low it SHALL capture Read_data+1 into a 32-bit data register, decrement that player's pending counter, and go to WR.
REQ-020 WR SHALL assert Chip_select_h, Write_h, Address=player and Write_data=data register until a cycle with Wait_h low, then return to IDLE.
REQ-021 Strobes SHALL be registered outputs, and Read_h and Write_h SHALL never be high in the same cycle.
REQ-022 All strobes SHALL be low in IDLE.
REQ-023 Best-case score update SHALL take 3 cycles: IDLE, RD, WR.
REQ-024 Each player SHALL have a pending counter of width PEND_W that increments on its point pulse.
REQ-025 A pulse arriving when the counter is at all-ones SHALL be dropped and SHALL set Overflow.
REQ-026 A pulse coinciding with the decrement in RD SHALL leave the counter unchanged.
REQ-027 A State_req arriving while one is already pending SHALL overwrite the latched value; only the last value is written.
REQ-028 Simultaneous P1_point, P2_point and State_req SHALL each be recorded in the same cycle.

Reset
REQ-029 Reset_h high SHALL immediately force the FSM to IDLE, all strobes low, Address=0, Write_data=0, pending counters=0, state request cleared, Overflow=0 and Busy=0.
REQ-030 Reset asserted mid-transfer SHALL abandon that transfer without issuing a completing write.

Configuration
REQ-031 With SCORE_SAT_EN defined, the incremented value SHALL be min(Read_data+1, MAX_SCORE), and Read_data >= MAX_SCORE SHALL write MAX_SCORE.
REQ-032 Without SCORE_SAT_EN, the incremented value SHALL be Read_data+1 modulo 2^32, and MAX_SCORE SHALL be unused.

Structure
REQ-033 Shared package game_pkg SHALL hold the FSM state enum, the register-address constants (ADDR_STATE=0, ADDR_P1=1, ADDR_P2=2) and the default MAX_SCORE.
REQ-034 A sub-module pend_counter (saturating up/down counter with overflow pulse) SHALL be instantiated once per player.

Verification
REQ-035 P1_point pulse, Wait_h=0, slave P1 score=5: RD at Address 1 then WR of 6, with Busy low on the 4th cycle.
REQ-036 P1_point, P2_point and State_req (State_val=3) in the same cycle: order SHALL be write 3 to addr 0, then RMW addr 1, then RMW addr 2.
REQ-037 Wait_h held high 4 cycles during WR: Write_h and Write_data SHALL stay stable, and exactly one write SHALL be accepted.
REQ-038 20 P2_point pulses while the bus is stalled, PEND_W=4: 15 increments completed, Overflow=1.
REQ-039 SCORE_SAT_EN defined, P1 score=999, P1_point: 999 written; without the macro, score 32'hFFFFFFFF → 0 written.
REQ-040 Reset_h pulsed during RD: strobes drop in the same cycle, no write occurs, and the pending counters read 0.
